// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared constants, funct3 encodings and FSM states for the sequential multiplier.
// MUL_SEQ_RADIX4_EN selects two multiplier bits per CALC cycle instead of one.
package mul_seq_pkg;
    localparam int XLEN    = 32;
    localparam int ITER_R2 = 32;
    localparam int ITER_R4 = 16;
`ifdef MUL_SEQ_RADIX4_EN
    localparam int ITERS = ITER_R4;
`else
    localparam int ITERS = ITER_R2;
`endif
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: request/result handshake bundle between the multiplier and its client.
interface mul_seq_if;
    import mul_seq_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic [4:0]      rd_out;
    logic            busy;
    modport slave (input in_valid, a, b, funct3, rd_in, flush, out_ready,
                   output in_ready, out_valid, y, rd_out, busy);
    modport master (output in_valid, a, b, funct3, rd_in, flush, out_ready,
                    input in_ready, out_valid, y, rd_out, busy);
endinterface

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: unsigned shift-add datapath over 32-bit magnitudes into a 64-bit product.
// MUL_SEQ_RADIX4_EN retires two multiplier bits per step.
module mul_shift_add_core
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [XLEN-1:0]   i_mcand,
    input  logic [XLEN-1:0]   i_mplier,
    output logic [2*XLEN-1:0] o_prod,
    output logic              o_zero
);
    logic [2*XLEN-1:0] r_prod, r_mcand, w_pp;
    logic [XLEN-1:0]   r_mplier;
`ifdef MUL_SEQ_RADIX4_EN
    localparam int STEP = 2;
    assign w_pp = (r_mplier[0] ? r_mcand : '0) + (r_mplier[1] ? {r_mcand[2*XLEN-2:0], 1'b0} : '0);
`else
    localparam int STEP = 1;
    assign w_pp = r_mplier[0] ? r_mcand : '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_prod   <= '0;
            r_mcand  <= {{XLEN{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
        end else if (i_step) begin
            r_prod   <= r_prod + w_pp;
            r_mcand  <= r_mcand << STEP;
            r_mplier <= r_mplier >> STEP;
        end
    end
    assign o_prod = r_prod;
    assign o_zero = (r_mcand == '0) || (r_mplier == '0);
endmodule

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: sequential RV32M MUL/MULH/MULHSU/MULHU unit with sign fix-up and valid/ready handshake.
// MUL_SEQ_RADIX4_EN halves the CALC phase (see mul_shift_add_core).
module mul_seq_unit
    import mul_seq_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mul_seq_if.slave  bus
);
    state_t            r_state, w_next;
    logic [4:0]        r_cnt;
    logic              r_chk, r_sign;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_y;
    logic              w_in_ready, w_take, w_neg_a, w_neg_b, w_zero, w_core_zero;
    logic [2*XLEN-1:0] w_prod, w_signed;
    logic [XLEN-1:0]   w_fix;
    assign w_in_ready = (r_state == IDLE) || (r_state == DONE && bus.out_ready);
    assign w_take     = bus.in_valid && w_in_ready && !bus.flush;
    assign w_neg_a    = bus.a[XLEN-1] && (bus.funct3[1:0] != 2'b11);
    assign w_neg_b    = bus.b[XLEN-1] && !bus.funct3[1];
    assign w_zero     = r_f3[2] || w_core_zero;
    assign w_signed   = r_sign ? -w_prod : w_prod;
    assign w_fix      = (r_f3[1:0] == F3_MUL[1:0]) ? w_signed[XLEN-1:0] : w_signed[2*XLEN-1:XLEN];
    mul_shift_add_core u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_take),
        .i_step   (r_state == CALC && !r_chk),
        .i_mcand  (w_neg_a ? -bus.a : bus.a),
        .i_mplier (w_neg_b ? -bus.b : bus.b),
        .o_prod   (w_prod),
        .o_zero   (w_core_zero)
    );
    // The first CALC cycle only screens for the zero/unsupported early-out.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_take ? CALC : IDLE;
            CALC: w_next = r_chk ? (w_zero ? DONE : CALC) : (r_cnt == 5'(ITERS - 1) ? FIX : CALC);
            FIX:  w_next = DONE;
            DONE: w_next = bus.out_ready ? (w_take ? CALC : IDLE) : DONE;
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_chk   <= 1'b0;
            r_sign  <= 1'b0;
            r_f3    <= '0;
            r_rd    <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_f3   <= bus.funct3;
                r_rd   <= bus.rd_in;
                r_sign <= w_neg_a ^ w_neg_b;
                r_chk  <= 1'b1;
                r_cnt  <= '0;
            end else if (r_state == CALC) begin
                r_chk <= 1'b0;
                r_cnt <= r_chk ? r_cnt : r_cnt + 5'd1;
            end
            if (r_state == CALC && r_chk && w_zero && !bus.flush) r_y <= '0;
            if (r_state == FIX && !bus.flush) r_y <= w_fix;
        end
    end
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.y         = r_y;
    assign bus.rd_out    = r_rd;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: directed vectors for mul_seq_unit with hand-computed results and latencies.
module tb_mul_seq_unit;
    import mul_seq_pkg::*;
`ifdef MUL_SEQ_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   lat;
    mul_seq_if bus ();
    mul_seq_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.a        = a;
        bus.b        = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!bus.out_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic deliver();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_deliver_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_y, input int exp_lat);
        issue(f3, a, b, rd);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_y"}, bus.y, exp_y);
        check({tag, "_rd"}, 32'(bus.rd_out), 32'(rd));
        deliver();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.funct3    = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", bus.y, 32'd0);
        check("rst_rd", 32'(bus.rd_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        run("mul_neg", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, LAT);
        run("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, LAT);
        run("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, LAT);
        run("mulhsu_max", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, LAT);
        run("mul_zero", F3_MUL, 32'd0, 32'h1234_5678, 5'd5, 32'd0, 1);
        run("div_op", 3'b100, 32'd3, 32'd5, 5'd6, 32'd0, 1);

        issue(F3_MUL, 32'd3, 32'd5, 5'd9);
        wait_done(lat);
        check("stall_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_y", bus.y, 32'd15);
            check("stall_rd", 32'(bus.rd_out), 32'd9);
        end
        bus.out_ready = 1'b1;
        issue(F3_MUL, 32'd2, 32'd3, 5'd12);
        bus.out_ready = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_valid", 32'(bus.out_valid), 32'd0);
        wait_done(lat);
        check("b2b_lat", 32'(lat), 32'(LAT));
        check("b2b_y", bus.y, 32'd6);
        check("b2b_rd", 32'(bus.rd_out), 32'd12);
        deliver();

        issue(F3_MUL, 32'd3, 32'd5, 5'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        wait_done(lat);
        check("flush_no_result", 32'(bus.out_valid), 32'd0);

        bus.flush = 1'b1;
        issue(F3_MUL, 32'd3, 32'd5, 5'd8);
        bus.flush = 1'b0;
        check("flush_accept_busy", 32'(bus.busy), 32'd0);

        issue(F3_MUL, 32'd0, 32'd5, 5'd10);
        wait_done(lat);
        check("flush_done_pre", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        check("flush_done_valid", 32'(bus.out_valid), 32'd0);
        check("flush_done_busy", 32'(bus.busy), 32'd0);

        run("pre_rst", F3_MUL, 32'd4, 32'd5, 5'd11, 32'd20, LAT);
        issue(F3_MULHU, 32'd9, 32'd9, 5'd13);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_y", bus.y, 32'd0);
        check("mid_rst_rd", 32'(bus.rd_out), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run("mulhu_two", F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd14, 32'd1, LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
